// File: rtl/riscv_mem_responder.sv
// Memory and MMIO responder for the pipelined core: dual-port word RAM with
// registered reads, plus TX byte FIFO, free-running cycle counter and exit register.
module riscv_mem_responder #(
  parameter int MEM_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  input  logic        dmem_write_i,
  input  logic        dmem_read_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        halt_o,
  output logic [30:0] exit_code_o
);

  localparam int RAM_WORDS = 1 << MEM_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLES = 2'd2,
    REG_EXIT   = 2'd3
  } mmio_reg_e;

  logic [31:0]          ram [RAM_WORDS];
  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic [31:0]          cycle_count;
  logic                 overflow;

  logic [MEM_WIDTH-1:0] ram_idx, imem_idx;
  logic                 is_mmio;
  mmio_reg_e            mmio_reg;
  logic                 fifo_empty, fifo_full;
  logic                 ram_we, tx_push, exit_we, dmem_rd, status_rd;
  logic                 tx_pop, push_accept, push_drop;
  logic [31:0]          mmio_rdata;
  logic                 unused_addr_bits;

  assign ram_idx   = dmem_addr_i[MEM_WIDTH-1:0];
  assign imem_idx  = imem_addr_i[MEM_WIDTH-1:0];
  assign is_mmio   = dmem_addr_i[31];
  assign mmio_reg  = mmio_reg_e'(dmem_addr_i[1:0]);
  assign unused_addr_bits = ^{imem_addr_i[31:MEM_WIDTH], dmem_addr_i[30:MEM_WIDTH]};

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];

  // Writes take priority: a simultaneous read strobe is ignored entirely.
  assign dmem_rd     = dmem_read_i && !dmem_write_i;
  assign ram_we      = dmem_write_i && !is_mmio;
  assign tx_push     = dmem_write_i && is_mmio && (mmio_reg == REG_TXDATA);
  assign exit_we     = dmem_write_i && is_mmio && (mmio_reg == REG_EXIT);
  assign status_rd   = dmem_rd && is_mmio && (mmio_reg == REG_STATUS);
  assign tx_pop      = tx_valid_o && tx_ready_i;
  assign push_accept = tx_push && (!fifo_full || tx_pop);
  assign push_drop   = tx_push && fifo_full && !tx_pop;

  always_comb begin
    // NOTE: default first so every path assigns mmio_rdata and no latch is inferred.
    mmio_rdata = '0;
    case (mmio_reg)
      REG_TXDATA: mmio_rdata = '0;
      REG_STATUS: mmio_rdata = {29'd0, overflow, fifo_empty, fifo_full};
      REG_CYCLES: mmio_rdata = cycle_count;
      REG_EXIT:   mmio_rdata = {halt_o, exit_code_o};
      default:    mmio_rdata = '0;
    endcase
  end

  // NOTE: storage arrays carry no reset so they map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (reset_n && ram_we) ram[ram_idx] <= dmem_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset_n && push_accept) fifo_mem[wr_ptr[PTR_W-1:0]] <= dmem_data_i[7:0];
  end

  // NOTE: non-blocking assignments make the IMEM read see the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      imem_data_o <= '0;
      dmem_data_o <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      halt_o      <= 1'b0;
      exit_code_o <= '0;
    end else begin
      imem_data_o <= ram[imem_idx];
      cycle_count <= cycle_count + 32'd1;

      if (dmem_rd) dmem_data_o <= is_mmio ? mmio_rdata : ram[ram_idx];

      if (push_accept) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (tx_pop)      rd_ptr <= rd_ptr + (PTR_W+1)'(1);

      if (push_drop)      overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;

      if (exit_we) begin
        halt_o      <= 1'b1;
        exit_code_o <= dmem_data_i[30:0];
      end
    end
  end

endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Synthesizable responder for the pipelined core's IMEM and DMEM ports; replaces the behavioural bench RAM so the same core runs on FPGA and in simulation.
- Provides a word-addressed dual-port RAM with 1-cycle registered reads.
- Provides an MMIO region with a 4-entry TX byte FIFO, sent out over a valid/ready handshake to a UART, plus a free-running cycle counter and an exit/halt register.

Parameters:
- MEM_WIDTH, 10, log2 of RAM depth in 32-bit words.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, 2 to 16.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- imem_addr_i  in  32  instruction word address from core
- imem_data_o  out  32  instruction word, registered
- dmem_write_i  in  1  data write strobe
- dmem_read_i  in  1  data read strobe
- dmem_addr_i  in  32  data word address
- dmem_data_i  in  32  write data from core
- dmem_data_o  out  32  read data to core, registered
- tx_data_o  out  8  byte at FIFO head
- tx_valid_o  out  1  FIFO non-empty
- tx_ready_i  in  1  UART accepts byte when valid and ready are both high
- halt_o  out  1  sticky; set by a write to EXIT
- exit_code_o  out  31  value written to EXIT, bits [30:0]

Behaviour:
- Reset: clk and reset_n as already decided; reset is synchronous and active-low.
  - imem_data_o, dmem_data_o, tx_data_o and exit_code_o go to 0; tx_valid_o and halt_o go to 0.
  - FIFO is emptied, cycle counter cleared, overflow flag cleared.
  - RAM contents are not reset.
  - Reset asserted mid-transfer discards FIFO contents; no partial handshake survives.
- Decode: dmem_addr_i[31]=0 selects RAM, indexed by addr[MEM_WIDTH-1:0]; upper bits below bit 31 are ignored, so the RAM aliases.
- dmem_addr_i[31]=1 selects MMIO, decoded on addr[1:0]:
  - 0 TXDATA: write pushes data[7:0] to the FIFO; reads return 0.
  - 1 STATUS, read-only: bit0 full, bit1 empty, bit2 overflow, other bits 0.
  - 2 CYCLES: read returns the 32-bit counter; writes are ignored.
  - 3 EXIT: write sets halt_o=1 and exit_code_o=data[30:0]; reads return {halt_o, exit_code_o}.
- IMEM port:
  - Every cycle out of reset, imem_data_o <= RAM[imem_addr_i[MEM_WIDTH-1:0]], giving 1-cycle latency.
  - MMIO is not visible on IMEM; bit 31 is ignored there.
- DMEM port:
  - Write has priority. If dmem_write_i=1, the write is performed and dmem_data_o holds its previous value, even when dmem_read_i=1.
  - Else if dmem_read_i=1, dmem_data_o <= selected data on the next edge.
  - Else dmem_data_o holds.
- Same-cycle collision (IMEM read and DMEM write to the same RAM word): IMEM returns the old word (read-before-write); the new word is visible from the next cycle.
- Cycle counter: increments by 1 every cycle out of reset, wraps 0xFFFFFFFF to 0. A CYCLES read returns the value sampled at the edge that registers the read.
- TX FIFO:
  - tx_data_o is the head entry; tx_valid_o = !empty.
  - A pop occurs when tx_valid_o && tx_ready_i.
  - Push when full, with no simultaneous pop: the byte is dropped and overflow is set (sticky). A STATUS read clears overflow on the same edge that returns it as 1.
  - Push and pop in the same cycle while full: both occur, no overflow, count unchanged.
  - Push and pop in the same cycle while empty: impossible, since tx_valid_o=0.
  - Push to an empty FIFO: tx_valid_o rises on the next cycle.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH.
- Halt: halt_o stays 1 until reset; later EXIT writes update exit_code_o. halt_o does not gate any other behaviour.

Test Plan:
- RAM write/read: write 0xDEADBEEF to addr 5, then read addr 5 -> dmem_data_o=0xDEADBEEF one cycle after the read strobe; a read of addr 5+2^MEM_WIDTH also returns 0xDEADBEEF.
- IMEM collision: preload addr 3=0x11111111; in one cycle set IMEM addr 3 and DMEM write 0x22222222 to addr 3 -> imem_data_o=0x11111111 that cycle, 0x22222222 the next.
- Write priority: assert read and write together to addr 7 with dmem_data_o=0xA5A5A5A5 -> dmem_data_o stays 0xA5A5A5A5 and RAM[7] is updated.
- FIFO full and overflow: tx_ready_i=0, push 0x41..0x45 -> STATUS=0x5 (full, overflow); a second STATUS read returns 0x1; raising tx_ready_i drains 0x41,0x42,0x43,0x44 in order, then STATUS=0x2.
- Simultaneous push/pop while full, then reset: FIFO full, tx_ready_i=1, push 0x55 -> count stays 4, no overflow, 0x55 appears last; assert reset_n=0 mid-drain -> tx_valid_o=0 next cycle.
- Counter and exit: read CYCLES 10 cycles after reset release -> value 9 or 10 consistent with sampling rule; write 0x0000002A to EXIT -> halt_o=1, exit_code_o=42; EXIT read -> 0x8000002A.
